gray_code_counter: RTL

//  Registered up/down binary counter that emits a Gray-coded stream (g = b ^ (b >> 1)).

---
 rtl/gray_code_counter.sv | 100 ++++++++++
 1 files changed

// File: rtl/gray_code_counter.sv
// Up/down binary counter presenting Gray-coded words over a valid/ready handshake.
// Define GRAY_CHECK_EN to add the par_out parity bit and the sticky step_err monitor.
module gray_code_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             wrap
`ifdef GRAY_CHECK_EN
   ,
   output logic             par_out,
   output logic             step_err
`endif
);

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic             accept;
   logic             slot;
   logic             step;
   logic             upd;
   logic             wrap_next;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_next;

   // A step may only advance when the output slot is free or being drained this cycle.
   always_comb begin
      accept    = out_valid & out_ready;
      slot      = ~out_valid | out_ready;
      step      = en & ~load & slot;
      upd       = load | step;
      cnt_next  = up_dn ? (bin_out + ONE) : (bin_out - ONE);
      wrap_next = up_dn ? (bin_out == ALL_ONES) : (bin_out == ZERO);
      bin_next  = load ? load_bin : cnt_next;
      gray_next = to_gray(bin_next);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_out   <= '0;
         gray_out  <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else if (upd) begin
         bin_out   <= bin_next;
         gray_out  <= gray_next;
         out_valid <= 1'b1;
         wrap      <= step & wrap_next;
      end else begin
         if (accept) begin
            out_valid <= 1'b0;
         end
         wrap <= 1'b0;
      end
   end

`ifdef GRAY_CHECK_EN
   logic [WIDTH-1:0] last_gray;
   logic             have_prev;

   // A load breaks the chain, so the next accepted word is never compared to anything older.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_out   <= 1'b0;
         step_err  <= 1'b0;
         last_gray <= '0;
         have_prev <= 1'b0;
      end else begin
         if (upd) begin
            par_out <= ^gray_next;
         end
         if (accept && have_prev && ($countones(gray_out ^ last_gray) != 1)) begin
            step_err <= 1'b1;
         end
         if (load) begin
            have_prev <= 1'b0;
         end else if (accept) begin
            have_prev <= 1'b1;
            last_gray <= gray_out;
         end
      end
   end
`endif

endmodule
